mult_div_unit: RTL and testbench

- Sequential MIPS multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits downstream of the register-file read ports, beside the ALU; results go to the HI/LO registers read by MFHI/MFLO.
- Iterates with one shared add/subtract datapath: shift-add for multiply, restoring division for divide, N iterations per operation.
- A start/busy/done handshake lets control stall the pipeline until HI/LO are valid.

---
 rtl/mult_div_unit_pkg.sv | 22 ++
 rtl/mult_div_unit_add_sub.sv | 16 +
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, state encoding and sizing helper for the MIPS multiply/divide unit.
package mult_div_unit_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/mult_div_unit_add_sub.sv
// n-bit adder/subtractor: s = x + y when subOrCin is 0, s = x - y when it is 1.
module nBitAddSub #(
   parameter int unsigned n = 8
) (
   input  logic [n-1:0] x,
   input  logic [n-1:0] y,
   input  logic         subOrCin,
   output logic [n-1:0] s,
   output logic         cout
);

   always_comb begin
      {cout, s} = {1'b0, x} + {1'b0, y ^ {n{subOrCin}}} + {{n{1'b0}}, subOrCin};
   end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit: one shared add/subtract datapath, N iterations per op,
// results written to HI/LO together with a one-cycle done pulse.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rstN,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo,
   output logic         divByZero
);

   localparam int unsigned CW = clog2(N);
   localparam logic [CW-1:0] LastIter = CW'(N - 1);

   state_e          state_q, state_d;
   logic            div_q, div_d;
   logic            neg_q, neg_d;
   logic            sign_a_q, sign_a_d;
   logic            bz_q, bz_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    acc_q, acc_d;
   logic [N-1:0]    mq_q, mq_d;
   logic [N-1:0]    md_q, md_d;
   logic [N-1:0]    a_raw_q, a_raw_d;
   logic [N-1:0]    hi_q, hi_d;
   logic [N-1:0]    lo_q, lo_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            dz_q, dz_d;

   logic            op_div;
   logic            op_signed;
   logic [N-1:0]    abs_a;
   logic [N-1:0]    abs_b;
   logic [N:0]      add_x;
   logic [N:0]      add_y;
   logic [N:0]      add_s;
   logic            add_cout;
   logic [N:0]      mul_part;
   logic [2*N-1:0]  prod;

   assign op_div    = (op == OP_DIVU) || (op == OP_DIV);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign abs_a     = (op_signed && a[N-1]) ? -a : a;
   assign abs_b     = (op_signed && b[N-1]) ? -b : b;

   // Multiply adds with both operands moved up one place so the carry out lands on cout;
   // divide subtracts the divisor from the left-shifted remainder.
   assign add_x = div_q ? {acc_q, mq_q[N-1]} : {acc_q, 1'b0};
   assign add_y = div_q ? {1'b0, md_q} : {md_q, 1'b0};

   nBitAddSub #(
      .n(N + 1)
   ) u_add_sub (
      .x       (add_x),
      .y       (add_y),
      .subOrCin(div_q),
      .s       (add_s),
      .cout    (add_cout)
   );

   assign mul_part = mq_q[0] ? {add_cout, add_s[N:1]} : {1'b0, acc_q};
   assign prod     = {acc_q, mq_q};

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      neg_d    = neg_q;
      sign_a_d = sign_a_q;
      bz_d     = bz_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mq_d     = mq_q;
      md_d     = md_q;
      a_raw_d  = a_raw_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dz_d     = dz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = CALC;
               div_d    = op_div;
               neg_d    = op_signed && (a[N-1] ^ b[N-1]);
               sign_a_d = op_signed && a[N-1];
               bz_d     = op_div && (b == '0);
               cnt_d    = '0;
               acc_d    = '0;
               mq_d     = op_div ? abs_a : abs_b;
               md_d     = op_div ? abs_b : abs_a;
               a_raw_d  = a;
               busy_d   = 1'b1;
               dz_d     = 1'b0;
            end
         end
         CALC: begin
            if (div_q) begin
               // Negative trial (sign bit set) keeps the shifted remainder.
               acc_d = add_s[N] ? {acc_q[N-2:0], mq_q[N-1]} : add_s[N-1:0];
               mq_d  = {mq_q[N-2:0], ~add_s[N]};
            end else begin
               acc_d = mul_part[N:1];
               mq_d  = {mul_part[0], mq_q[N-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LastIter) state_d = FIX;
         end
         FIX: begin
            if (!div_q) begin
               {hi_d, lo_d} = neg_q ? -prod : prod;
            end else if (bz_q) begin
               hi_d = a_raw_q;
               lo_d = '1;
            end else begin
               hi_d = sign_a_q ? -acc_q : acc_q;
               lo_d = neg_q ? -mq_q : mq_q;
            end
            dz_d    = bz_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q  <= IDLE;
         div_q    <= 1'b0;
         neg_q    <= 1'b0;
         sign_a_q <= 1'b0;
         bz_q     <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mq_q     <= '0;
         md_q     <= '0;
         a_raw_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         neg_q    <= neg_d;
         sign_a_q <= sign_a_d;
         bz_q     <= bz_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mq_q     <= mq_d;
         md_q     <= md_d;
         a_raw_q  <= a_raw_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign divByZero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: an 8-bit and a 32-bit instance checked every cycle against an
// arithmetic model, plus directed vectors with hand-computed results.
module tb_mult_div_unit;

   typedef struct packed {
      logic [63:0] hi;
      logic [63:0] lo;
      logic        dz;
   } res_t;

   logic        clk;
   logic        rstN;
   logic        start_s [2];
   logic [1:0]  op_s    [2];
   logic [63:0] a_s     [2];
   logic [63:0] b_s     [2];
   logic        busy_s  [2];
   logic        done_s  [2];
   logic        dz_s    [2];
   logic [7:0]  hi8, lo8;
   logic [31:0] hi32, lo32;

   int checks = 0;
   int errors = 0;

   int          m_left [2];
   logic        m_done [2];
   logic [63:0] m_hi   [2];
   logic [63:0] m_lo   [2];
   logic        m_dz   [2];
   res_t        m_pend [2];

   mult_div_unit #(.N(8)) u_dut8 (
      .clk      (clk),
      .rstN     (rstN),
      .start    (start_s[0]),
      .op       (op_s[0]),
      .a        (a_s[0][7:0]),
      .b        (b_s[0][7:0]),
      .busy     (busy_s[0]),
      .done     (done_s[0]),
      .hi       (hi8),
      .lo       (lo8),
      .divByZero(dz_s[0])
   );

   mult_div_unit #(.N(32)) u_dut32 (
      .clk      (clk),
      .rstN     (rstN),
      .start    (start_s[1]),
      .op       (op_s[1]),
      .a        (a_s[1][31:0]),
      .b        (b_s[1][31:0]),
      .busy     (busy_s[1]),
      .done     (done_s[1]),
      .hi       (hi32),
      .lo       (lo32),
      .divByZero(dz_s[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int width(input int k);
      return (k == 0) ? 8 : 32;
   endfunction

   function automatic logic [63:0] dut_hi(input int k);
      return (k == 0) ? {56'd0, hi8} : {32'd0, hi32};
   endfunction

   function automatic logic [63:0] dut_lo(input int k);
      return (k == 0) ? {56'd0, lo8} : {32'd0, lo32};
   endfunction

   // Architectural result of one operation at width n, from plain integer arithmetic.
   function automatic res_t model_op(input int n, input logic [1:0] o, input logic [63:0] x,
                                     input logic [63:0] y);
      res_t        r;
      logic [63:0] mask, ua, ub, p;
      longint      sa, sb;
      mask = (64'd1 << n) - 64'd1;
      ua   = x & mask;
      ub   = y & mask;
      sa   = longint'(ua << (64 - n)) >>> (64 - n);
      sb   = longint'(ub << (64 - n)) >>> (64 - n);
      r    = '0;
      if (o[1] == 1'b0) begin
         if (o[0]) p = 64'(sa * sb);
         else      p = ua * ub;
         r.hi = (p >> n) & mask;
         r.lo = p & mask;
      end else if (ub == 64'd0) begin
         r.hi = ua;
         r.lo = mask;
         r.dz = 1'b1;
      end else if (o[0] == 1'b0) begin
         r.lo = ua / ub;
         r.hi = ua % ub;
      end else begin
         r.lo = 64'(sa / sb) & mask;
         r.hi = 64'(sa % sb) & mask;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Timing model: an accepted start makes results visible N+1 edges later.
   always @(posedge clk or negedge rstN) begin
      for (int k = 0; k < 2; k++) begin
         if (!rstN) begin
            m_left[k] <= 0;
            m_done[k] <= 1'b0;
            m_hi[k]   <= '0;
            m_lo[k]   <= '0;
            m_dz[k]   <= 1'b0;
            m_pend[k] <= '0;
         end else begin
            m_done[k] <= 1'b0;
            if (m_left[k] == 0) begin
               if (start_s[k] === 1'b1) begin
                  m_pend[k] <= model_op(width(k), op_s[k], a_s[k], b_s[k]);
                  m_left[k] <= width(k) + 1;
                  m_dz[k]   <= 1'b0;
               end
            end else begin
               if (m_left[k] == 1) begin
                  m_hi[k]   <= m_pend[k].hi;
                  m_lo[k]   <= m_pend[k].lo;
                  m_dz[k]   <= m_pend[k].dz;
                  m_done[k] <= 1'b1;
               end
               m_left[k] <= m_left[k] - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("cyc_busy%0d", k), {63'd0, busy_s[k]}, {63'd0, m_left[k] != 0});
         chk($sformatf("cyc_done%0d", k), {63'd0, done_s[k]}, {63'd0, m_done[k]});
         chk($sformatf("cyc_dz%0d", k), {63'd0, dz_s[k]}, {63'd0, m_dz[k]});
         chk($sformatf("cyc_hi%0d", k), dut_hi(k), m_hi[k]);
         chk($sformatf("cyc_lo%0d", k), dut_lo(k), m_lo[k]);
      end
   end

   // Caller sits at a negedge; returns at the negedge after the start edge.
   task automatic launch(input int k, input logic [1:0] o, input logic [63:0] x,
                         input logic [63:0] y);
      start_s[k] = 1'b1;
      op_s[k]    = o;
      a_s[k]     = x;
      b_s[k]     = y;
      @(negedge clk);
      start_s[k] = 1'b0;
      op_s[k]    = 2'($urandom);
      a_s[k]     = {$urandom, $urandom};
      b_s[k]     = {$urandom, $urandom};
   endtask

   task automatic wait_done(input int k, input int budget, output int edges);
      edges = 0;
      while (done_s[k] !== 1'b1 && edges < budget) begin
         @(negedge clk);
         edges++;
      end
      if (done_s[k] !== 1'b1) chk("done_timeout", {63'd0, done_s[k]}, 64'd1);
   endtask

   task automatic run(input int k, input logic [1:0] o, input logic [63:0] x,
                      input logic [63:0] y, input logic [63:0] eh, input logic [63:0] el,
                      input logic ed, input string nm);
      int e;
      launch(k, o, x, y);
      chk({nm, "_dzclr"}, {63'd0, dz_s[k]}, 64'd0);
      wait_done(k, width(k) + 10, e);
      chk({nm, "_lat"}, 64'(e), 64'(width(k) + 1));
      chk({nm, "_hi"}, dut_hi(k), eh);
      chk({nm, "_lo"}, dut_lo(k), el);
      chk({nm, "_dz"}, {63'd0, dz_s[k]}, {63'd0, ed});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      res_t r;
      int   e;
      rstN = 1'b0;
      for (int k = 0; k < 2; k++) begin
         start_s[k] = 1'b0;
         op_s[k]    = 2'b00;
         a_s[k]     = '0;
         b_s[k]     = '0;
      end
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, busy_s[1]}, 64'd0);
      chk("rst_hi", dut_hi(1), 64'd0);
      chk("rst_lo", dut_lo(0), 64'd0);
      rstN = 1'b1;
      @(negedge clk);

      r = model_op(8, 2'b01, 64'hFD, 64'h05);
      chk("model_mult", {r.hi, r.lo}, {64'hFF, 64'hF1});
      r = model_op(8, 2'b11, 64'h80, 64'hFF);
      chk("model_div", {r.hi, r.lo}, {64'h00, 64'h80});

      run(0, 2'b00, 64'hFF, 64'hFF, 64'hFE, 64'h01, 1'b0, "multu_ff");
      run(0, 2'b01, 64'hFD, 64'h05, 64'hFF, 64'hF1, 1'b0, "mult_m3x5");
      run(0, 2'b11, 64'hF9, 64'h02, 64'hFF, 64'hFD, 1'b0, "div_m7d2");
      run(0, 2'b10, 64'h64, 64'h00, 64'h64, 64'hFF, 1'b1, "divu_by0");
      run(0, 2'b11, 64'h80, 64'hFF, 64'h00, 64'h80, 1'b0, "div_min_m1");
      run(0, 2'b01, 64'h80, 64'h80, 64'h40, 64'h00, 1'b0, "mult_minmin");
      run(0, 2'b11, 64'h85, 64'h00, 64'h85, 64'hFF, 1'b1, "div_by0");
      run(0, 2'b01, 64'hFF, 64'hFF, 64'h00, 64'h01, 1'b0, "mult_m1m1");
      run(0, 2'b10, 64'hC8, 64'h07, 64'h04, 64'h1C, 1'b0, "divu_200d7");

      @(negedge clk);
      r = model_op(32, 2'b00, 64'h12345678, 64'h9ABCDEF0);
      run(1, 2'b00, 64'h12345678, 64'h9ABCDEF0, r.hi, r.lo, 1'b0, "multu32");
      // Back-to-back: launched from the done cycle of the previous op.
      run(1, 2'b11, 64'h80000000, 64'hFFFFFFFF, 64'h0, 64'h80000000, 1'b0, "div32_min");
      run(1, 2'b01, 64'h80000000, 64'h80000000, 64'h40000000, 64'h0, 1'b0, "mult32_minmin");

      // A start pulse mid-operation must be ignored.
      launch(1, 2'b10, 64'd1000, 64'd7);
      repeat (4) @(negedge clk);
      start_s[1] = 1'b1;
      op_s[1]    = 2'b00;
      a_s[1]     = 64'd5;
      b_s[1]     = 64'd6;
      @(negedge clk);
      start_s[1] = 1'b0;
      wait_done(1, 40, e);
      chk("ign_lat", 64'(e + 5), 64'd33);
      chk("ign_lo", dut_lo(1), 64'd142);
      chk("ign_hi", dut_hi(1), 64'd6);

      for (int i = 0; i < 6; i++) begin
         logic [1:0]  o;
         logic [63:0] x, y;
         o = 2'(i);
         x = {32'd0, $urandom};
         y = (i == 5) ? 64'd0 : {32'd0, $urandom >> (i * 4)};
         r = model_op(32, o, x, y);
         run(1, o, x, y, r.hi, r.lo, r.dz, "rand32");
      end

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      launch(1, 2'b11, 64'hFFFFFF9C, 64'd7);
      repeat (9) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      chk("mrst_busy", {63'd0, busy_s[1]}, 64'd0);
      chk("mrst_done", {63'd0, done_s[1]}, 64'd0);
      chk("mrst_dz", {63'd0, dz_s[1]}, 64'd0);
      chk("mrst_hi", dut_hi(1), 64'd0);
      chk("mrst_lo", dut_lo(1), 64'd0);
      chk("mrst_hi8", dut_hi(0), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      run(1, 2'b00, 64'd3, 64'd4, 64'd0, 64'h0C, 1'b0, "multu_3x4");
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
